// File: rtl/packet_register_bridge_pkg.sv
// ---------------------------------------------------------------------------
// packet_register_bridge_pkg
//   Shared definitions for the byte-stream to register-bus bridge:
//   command codes, the parser state enumeration and a state classifier.
//   Optional feature macro: BRIDGE_CHECKSUM_EN adds the CSUM parser state.
// ---------------------------------------------------------------------------
package packet_register_bridge_pkg;

    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
`ifdef BRIDGE_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_WRITE,
        ST_RD_WAIT,
        ST_TX
    } bridge_state_t;

    // Receive states are the ones in which the bridge accepts bytes.
    function automatic logic is_rx_state(input bridge_state_t s);
        return !(s inside {ST_WRITE, ST_RD_WAIT, ST_TX});
    endfunction

endpackage

// File: rtl/packet_register_bridge_tx_byte_serialiser.sv
// ---------------------------------------------------------------------------
// tx_byte_serialiser
//   Loads a 32-bit read word and emits SYNC_BYTE followed by the word LSB
//   first (plus an XOR checksum byte when BRIDGE_CHECKSUM_EN is defined)
//   on a valid/ready byte stream. done_o pulses with the final handshake.
// Ports
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   load_i      start a response with word_i
//   word_i      32-bit word to send
//   tx_data_o   byte being offered (0 when idle)
//   tx_valid_o  tx_data_o valid
//   tx_ready_i  downstream accepts the byte
//   done_o      last byte accepted this cycle
// ---------------------------------------------------------------------------
module tx_byte_serialiser #(
    parameter logic [7:0] SYNC_BYTE = 8'h55
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] word_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        done_o
);

`ifdef BRIDGE_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif

    logic [31:0] word_q, word_d;
    logic [2:0]  idx_q, idx_d;
    logic        active_q, active_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  byte_out;
    logic        fire;

    // Index 0 is the sync byte, 1..4 come from the shift register's low byte,
    // 5 (checksum builds only) is the running XOR of everything sent so far.
    always_comb begin
        byte_out = 8'h00;
        if (active_q) begin
            if (idx_q == 3'd0) begin
                byte_out = SYNC_BYTE;
            end else if (idx_q <= 3'd4) begin
                byte_out = word_q[7:0];
            end else begin
                byte_out = csum_q;
            end
        end
    end

    assign fire       = active_q & tx_ready_i;
    assign done_o     = fire && (idx_q == LAST_IDX);
    assign tx_data_o  = byte_out;
    assign tx_valid_o = active_q;

    always_comb begin
        word_d   = word_q;
        idx_d    = idx_q;
        active_d = active_q;
        csum_d   = csum_q;
        if (load_i) begin
            word_d   = word_i;
            idx_d    = 3'd0;
            active_d = 1'b1;
            csum_d   = 8'h00;
        end else if (fire) begin
            csum_d = csum_q ^ byte_out;
            if (idx_q != 3'd0) begin
                word_d = {8'h00, word_q[31:8]};
            end
            if (idx_q == LAST_IDX) begin
                active_d = 1'b0;
                idx_d    = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q   <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
            csum_q   <= '0;
        end else begin
            word_q   <= word_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            csum_q   <= csum_d;
        end
    end

endmodule

// File: rtl/packet_register_bridge.sv
// ---------------------------------------------------------------------------
// packet_register_bridge
//   Parses command packets (SYNC, CMD, ADDR, [4 data bytes LSB first]) from a
//   received byte stream and acts as register-bus master: writes produce a
//   single-cycle write strobe, reads sample the bus after RD_LATENCY and send
//   SYNC + 4 data bytes back on the transmit stream.
//   Optional macro BRIDGE_CHECKSUM_EN: packets and read responses carry a
//   trailing XOR checksum byte; bad request checksums abort the packet.
// Ports
//   ipClk / ipReset         clock, asynchronous active-low reset
//   ipRxData/ipRxValid/opRxReady   receive byte stream
//   opTxData/opTxValid/ipTxReady   transmit byte stream
//   opAddress/opWrData/opWrEnable  register bus write side
//   ipRdData                register bus read data
//   opErrorCount            saturating count of aborted packets
// ---------------------------------------------------------------------------
module packet_register_bridge
    import packet_register_bridge_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = 8'h55,
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  logic [7:0]  ipRxData,
    input  logic        ipRxValid,
    output logic        opRxReady,
    output logic [7:0]  opTxData,
    output logic        opTxValid,
    input  logic        ipTxReady,
    output logic [7:0]  opAddress,
    output logic [31:0] opWrData,
    output logic        opWrEnable,
    input  logic [31:0] ipRdData,
    output logic [7:0]  opErrorCount
);

    localparam logic [15:0] RD_WAIT_LAST = 16'(RD_LATENCY);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    bridge_state_t state_q, state_d;
    logic          is_write_q, is_write_d;
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [15:0]   wait_q, wait_d;
    logic [31:0]   timeout_q, timeout_d;
    logic [7:0]    err_q, err_d;
    logic          rx_ready_q;
    logic          rx_fire;
    logic          err_inc;
    logic          tx_load;
    logic          tx_done;

`ifdef BRIDGE_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;

    // Running XOR of the request; the sync byte restarts it.
    always_comb begin
        csum_d = csum_q;
        if (rx_fire) begin
            if (state_q == ST_IDLE) begin
                csum_d = ipRxData;
            end else begin
                csum_d = csum_q ^ ipRxData;
            end
        end
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign rx_fire = ipRxValid & rx_ready_q;

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        byte_idx_d = byte_idx_q;
        wait_d     = '0;
        timeout_d  = '0;
        err_inc    = 1'b0;
        tx_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_fire && (ipRxData == SYNC_BYTE)) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rx_fire) begin
                    if ((ipRxData == CMD_READ) || (ipRxData == CMD_WRITE)) begin
                        is_write_d = (ipRxData == CMD_WRITE);
                        state_d    = ST_ADDR;
                    end else begin
                        err_inc = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_fire) begin
                    addr_d     = ipRxData;
                    byte_idx_d = 2'd0;
                    if (is_write_q) begin
                        state_d = ST_DATA;
                    end else begin
`ifdef BRIDGE_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_RD_WAIT;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (rx_fire) begin
                    wr_data_d[{byte_idx_q, 3'b000} +: 8] = ipRxData;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
`ifdef BRIDGE_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_WRITE;
`endif
                    end
                end
            end
`ifdef BRIDGE_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_fire) begin
                    if (ipRxData == csum_q) begin
                        state_d = is_write_q ? ST_WRITE : ST_RD_WAIT;
                    end else begin
                        err_inc = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_RD_WAIT: begin
                // Address settled one cycle before entry; RD_LATENCY+1 cycles
                // here leaves the read data settled when it is sampled.
                if (wait_q == RD_WAIT_LAST) begin
                    tx_load = 1'b1;
                    state_d = ST_TX;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            ST_TX: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Mid-packet inactivity watchdog. Only reachable without a byte this
        // cycle, so it never collides with a case-arm state change.
        if (is_rx_state(state_q) && (state_q != ST_IDLE) && !rx_fire) begin
            if (timeout_q == TIMEOUT_LAST) begin
                err_inc = 1'b1;
                state_d = ST_IDLE;
            end else begin
                timeout_d = timeout_q + 32'd1;
            end
        end
    end

    assign err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            byte_idx_q <= '0;
            wait_q     <= '0;
            timeout_q  <= '0;
            err_q      <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            byte_idx_q <= byte_idx_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
            // Registered so ready stays low through reset and rises one clock
            // after release.
            rx_ready_q <= is_rx_state(state_d);
        end
    end

    tx_byte_serialiser #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_tx (
        .clk_i      (ipClk),
        .rst_ni     (ipReset),
        .load_i     (tx_load),
        .word_i     (ipRdData),
        .tx_data_o  (opTxData),
        .tx_valid_o (opTxValid),
        .tx_ready_i (ipTxReady),
        .done_o     (tx_done)
    );

    assign opRxReady    = rx_ready_q;
    assign opAddress    = addr_q;
    assign opWrData     = wr_data_q;
    assign opWrEnable   = (state_q == ST_WRITE);
    assign opErrorCount = err_q;

endmodule

// File: tb/tb_packet_register_bridge.sv
// ---------------------------------------------------------------------------
// tb_packet_register_bridge
//   Randomised scoreboard bench for packet_register_bridge. Stimulus tasks
//   push expected writes / transmit bytes into queues; a monitor on the
//   falling edge pops and compares whenever the DUT presents them.
//   Honours BRIDGE_CHECKSUM_EN when defined.
// ---------------------------------------------------------------------------
module tb_packet_register_bridge;

    localparam logic [7:0] SYNC = 8'h55;
    localparam int         TO   = 100;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        ipClk = 1'b0;
    logic        ipReset;
    logic [7:0]  ipRxData;
    logic        ipRxValid;
    logic        opRxReady;
    logic [7:0]  opTxData;
    logic        opTxValid;
    logic        ipTxReady;
    logic [7:0]  opAddress;
    logic [31:0] opWrData;
    logic        opWrEnable;
    logic [31:0] ipRdData;
    logic [7:0]  opErrorCount;

    always #5 ipClk = ~ipClk;

    packet_register_bridge #(
        .SYNC_BYTE      (SYNC),
        .RD_LATENCY     (1),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ipClk        (ipClk),
        .ipReset      (ipReset),
        .ipRxData     (ipRxData),
        .ipRxValid    (ipRxValid),
        .opRxReady    (opRxReady),
        .opTxData     (opTxData),
        .opTxValid    (opTxValid),
        .ipTxReady    (ipTxReady),
        .opAddress    (opAddress),
        .opWrData     (opWrData),
        .opWrEnable   (opWrEnable),
        .ipRdData     (ipRdData),
        .opErrorCount (opErrorCount)
    );

    logic [31:0] bus_mem [256];
    logic [31:0] ref_mem [256];
    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_err  = 0;
    bit          bp_hold  = 1'b0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Register block model: one-cycle read latency, write on strobe.
    always @(posedge ipClk) begin
        if (opWrEnable) bus_mem[opAddress] <= opWrData;
        ipRdData <= bus_mem[opAddress];
    end

    // Transmit-side ready: random, or forced low for the backpressure test.
    initial begin
        ipTxReady = 1'b0;
        forever begin
            @(posedge ipClk);
            #1;
            ipTxReady = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        bit         stalled;
        logic [7:0] held;
        wr_t        w;
        stalled = 1'b0;
        held    = 8'h00;
        forever begin
            @(negedge ipClk);
            if (ipReset !== 1'b1) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check_eq("tx_hold_valid", opTxValid, 1);
                    check_eq("tx_hold_data", opTxData, held);
                    check_eq("rx_ready_during_tx", opRxReady, 0);
                end
                if (opTxValid && ipTxReady) begin
                    check_eq("tx_expected", exp_tx.size(), (exp_tx.size() == 0) ? 1 : exp_tx.size());
                    if (exp_tx.size() != 0) check_eq("tx_byte", opTxData, exp_tx.pop_front());
                end
                if (opWrEnable) begin
                    check_eq("wr_expected", exp_wr.size(), (exp_wr.size() == 0) ? 1 : exp_wr.size());
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        check_eq("wr_addr", opAddress, w.a);
                        check_eq("wr_data", opWrData, w.d);
                    end
                end
                stalled = opTxValid && !ipTxReady;
                held    = opTxData;
            end
        end
    end

    function automatic logic [7:0] xor_q(input bq_t q);
        logic [7:0] x = 8'h00;
        foreach (q[i]) x ^= q[i];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        ipRxValid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge ipClk);
        #1;
        ipRxData  = b;
        ipRxValid = 1'b1;
        forever begin
            @(negedge ipClk);
            if (opRxReady) break;
            guard++;
            if (guard > 500) begin
                check_eq("rx_accept_timeout", guard, 0);
                break;
            end
        end
        @(posedge ipClk);
        #1;
        ipRxValid = 1'b0;
    endtask

    task automatic send_pkt(input bq_t p);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input bit bad_csum);
        bq_t p;
        p = {SYNC, 8'h01, addr, data[7:0], data[15:8], data[23:16], data[31:24]};
`ifdef BRIDGE_CHECKSUM_EN
        p.push_back(xor_q(p) ^ {7'd0, bad_csum});
`endif
        if (bad_csum) begin
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end else begin
            exp_wr.push_back('{a: addr, d: data});
            ref_mem[addr] = data;
        end
        send_pkt(p);
    endtask

    task automatic do_read(input logic [7:0] addr);
        bq_t p;
        bq_t r;
        logic [31:0] d;
        p = {SYNC, 8'h00, addr};
`ifdef BRIDGE_CHECKSUM_EN
        p.push_back(xor_q(p));
`endif
        d = ref_mem[addr];
        r = {SYNC, d[7:0], d[15:8], d[23:16], d[31:24]};
`ifdef BRIDGE_CHECKSUM_EN
        r.push_back(xor_q(r));
`endif
        foreach (r[i]) exp_tx.push_back(r[i]);
        send_pkt(p);
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && g < 3000) begin
            @(posedge ipClk);
            g++;
        end
        repeat (3) @(posedge ipClk);
        #1;
        check_eq({name, "_drain"}, exp_tx.size() + exp_wr.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, "_rx_ready"}, opRxReady, 0);
        check_eq({name, "_tx_valid"}, opTxValid, 0);
        check_eq({name, "_tx_data"}, opTxData, 0);
        check_eq({name, "_addr"}, opAddress, 0);
        check_eq({name, "_wr_data"}, opWrData, 0);
        check_eq({name, "_wr_en"}, opWrEnable, 0);
        check_eq({name, "_err"}, opErrorCount, 0);
    endtask

    initial begin
        int guard;
        ipReset   = 1'b0;
        ipRxValid = 1'b0;
        ipRxData  = 8'h00;
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end
        bus_mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        bus_mem[9] = 32'hCAFEF00D;
        ref_mem[9] = 32'hCAFEF00D;

        // Reset state and ready release.
        repeat (3) @(posedge ipClk);
        #1;
        check_all_zero("reset");
        ipReset = 1'b1;
        check_eq("rx_ready_before_clock", opRxReady, 0);
        @(posedge ipClk);
        #1;
        check_eq("rx_ready_after_release", opRxReady, 1);

        // Basic write.
        do_write(8'h02, 32'h12345678, 1'b0);
        wait_drain("write");
        check_eq("write_addr_held", opAddress, 8'h02);
        check_eq("write_data_held", opWrData, 32'h12345678);

        // Basic read.
        do_read(8'h04);
        wait_drain("read");

        // Backpressure during the read response.
        bp_hold = 1'b1;
        do_read(8'h09);
        guard = 0;
        while (!opTxValid && guard < 100) begin
            @(posedge ipClk);
            #1;
            guard++;
        end
        check_eq("bp_tx_valid", opTxValid, 1);
        repeat (10) @(posedge ipClk);
        #1;
        check_eq("bp_rx_ready", opRxReady, 0);
        check_eq("bp_tx_data_sync", opTxData, SYNC);
        bp_hold = 1'b0;
        wait_drain("backpressure");

        // Noise then bad command, then a good write.
        send_pkt({8'h33, SYNC, 8'h07});
        exp_err++;
        check_eq("bad_cmd_err", opErrorCount, exp_err);
        do_write(8'h10, $urandom, 1'b0);
        wait_drain("after_bad_cmd");
        check_eq("bad_cmd_err_stable", opErrorCount, exp_err);

        // Timeout mid-packet.
        send_pkt({SYNC, 8'h01});
        repeat (TO - 10) @(posedge ipClk);
        #1;
        check_eq("timeout_not_yet", opErrorCount, exp_err);
        repeat (20) @(posedge ipClk);
        #1;
        exp_err++;
        check_eq("timeout_err", opErrorCount, exp_err);
        do_write(8'h11, $urandom, 1'b0);
        wait_drain("after_timeout");

`ifdef BRIDGE_CHECKSUM_EN
        do_write(8'h12, 32'hA5A5_5A5A, 1'b1);
        wait_drain("bad_csum");
        check_eq("bad_csum_err", opErrorCount, exp_err);
`endif

        // Randomised mix of reads, writes and bad commands.
        for (int t = 0; t < 60; t++) begin
            int kind;
            logic [7:0] a;
            kind = $urandom_range(0, 9);
            a    = 8'($urandom_range(0, 15));
            if (kind < 4) begin
                do_write(a, $urandom, 1'b0);
            end else if (kind < 9) begin
                do_read(a);
            end else begin
                send_pkt({SYNC, 8'($urandom_range(2, 255))});
                exp_err++;
            end
        end
        wait_drain("random");
        check_eq("random_err", opErrorCount, exp_err);

        // Error count saturation.
        for (int t = 0; t < 300; t++) begin
            send_pkt({SYNC, 8'($urandom_range(2, 255))});
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
        check_eq("err_saturated", opErrorCount, exp_err);

        // Asynchronous reset mid-packet.
        send_pkt({SYNC, 8'h01, 8'h02, 8'h78});
        #2;
        ipReset = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_err = 0;
        repeat (2) @(posedge ipClk);
        #1;
        ipReset = 1'b1;
        do_write(8'h02, 32'h12345678, 1'b0);
        wait_drain("post_reset_write");
        check_eq("post_reset_addr", opAddress, 8'h02);
        check_eq("post_reset_data", opWrData, 32'h12345678);
        check_eq("post_reset_err", opErrorCount, exp_err);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
